mc6809_clkgen: RTL and testbench
================================

# mc6809_clkgen

Clock-enable and reset sequencer between the board PLL and the MC6809 core. It runs on one PLL output clock and synchronises and filters the PLL lock indication. It then generates the 6809 quadrature E/Q phases with one-cycle edge strobes, and holds the CPU in reset for a fixed number of E cycles after lock is stable. The core, bus decode and memory interfaces use the strobes as clock enables, so they need no derived clocks.

## Interface
- `DIV`, default 10: clk cycles per quarter E period (E = clk/(4·DIV); 40 MHz → 1 MHz). Range 1..255.
- `LOCK_FILTER`, default 1024: consecutive synchronised-locked cycles required before starting E/Q. Range 1..65535.
- `RST_E_CYCLES`, default 8: number of E falling edges during which `cpu_reset` stays high after E/Q start. Range 1..255.

Ports:
- `clk` in 1: PLL output clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `pll_locked` in 1: PLL lock; asynchronous to `clk`.
- `stretch` in 1: hold E high (present only with `MC6809_CLKGEN_STRETCH_EN`).
- `e_out`, `q_out` out 1: registered E and Q levels.
- `e_rise`, `e_fall`, `q_rise`, `q_fall` out 1: one-cycle strobes.
- `cpu_reset` out 1: active-high CPU reset.
- `running` out 1: high in RUN state.

## Operation
- `pll_locked` passes through a 2-flop synchroniser, giving `lk_s`.
- The state machine has five states: RESET → WAIT_LOCK → FILTER → HOLD → RUN.
  - RESET: entered on `rst`. Moves to WAIT_LOCK on the first cycle with `rst`=0.
  - WAIT_LOCK: clears the filter counter. Moves to FILTER when `lk_s`=1.
  - FILTER: increments the counter while `lk_s`=1. Returns to WAIT_LOCK if `lk_s`=0. Moves to HOLD when the count reaches `LOCK_FILTER`.
  - HOLD: E/Q run and `cpu_reset`=1. Counts `e_fall` strobes and moves to RUN in the cycle of the `RST_E_CYCLES`-th one.
  - RUN: E/Q run, `cpu_reset`=0, `running`=1.
- If `lk_s`=0 in FILTER, HOLD or RUN, the block moves to WAIT_LOCK the next cycle:
  - phase and divide counters clear;
  - `e_out`/`q_out` are forced to 0 with no strobes emitted;
  - `cpu_reset`=1.
- There are four phases per E cycle, each `DIV` clk long, starting at phase 0 on HOLD entry:
  - phase 0: E=0, Q=0;
  - phase 1: E=0, Q=1;
  - phase 2: E=1, Q=1;
  - phase 3: E=1, Q=0.
- Strobe mapping: `q_rise` at phase 1 start, `e_rise` at phase 2 start, `q_fall` at phase 3 start, `e_fall` at the next phase 0 start. No `e_fall` is emitted on HOLD entry.
- The divide counter is $clog2(DIV) bits, or 1 bit when DIV=1, and wraps from DIV-1 to 0 while advancing the phase. The 2-bit phase counter wraps 3→0.
- The filter counter saturates and never wraps. The HOLD counter is $clog2(RST_E_CYCLES+1) bits.

## Timing
- Reset values:
  - `e_out`, `q_out`, all strobes, `running` = 0;
  - `cpu_reset` = 1;
  - state = RESET;
  - all counters = 0.
- A rise of `pll_locked` reaches FILTER after 3 cycles (2 synchroniser cycles plus the WAIT_LOCK decision). HOLD begins `LOCK_FILTER` cycles later.
- Each strobe is high exactly in the first cycle in which the registered level shows the new value.
- `cpu_reset` falls and `running` rises in the same cycle as the `RST_E_CYCLES`-th `e_fall`. This is the start of an E-low phase.
- When `rst` and lock loss occur together, `rst` wins.
- `rst` asserted mid-cycle forces all reset values on the next edge.

## Configuration
- `MC6809_CLKGEN_STRETCH_EN` defined:
  - the `stretch` port exists;
  - while `stretch`=1 in the last cycle of phase 3, the divide counter holds at DIV-1, so E stays 1, Q stays 0 and no `e_fall` is emitted;
  - the block advances to phase 0 on the first cycle after `stretch` returns to 0;
  - there is no stretch limit;
  - `stretch` is ignored outside HOLD/RUN.
- Undefined: the port is absent and E/Q free-run.

## Test plan
- DIV=2, LOCK_FILTER=8, RST_E_CYCLES=2, `pll_locked` held 1, release `rst` → `q_rise` 11 cycles later. E period is 8 clk with Q leading E by 2 clk. `cpu_reset` falls with the 2nd `e_fall` (16 clk after the first `q_rise` minus 2).
- Lock glitch during FILTER: `pll_locked` low 1 cycle at filter count 5 → counter restarts. First `q_rise` is delayed by the glitch length plus the 8-cycle filter.
- Lock loss in RUN while E=1 → within 3 cycles `e_out`=`q_out`=0, `cpu_reset`=1, `running`=0, and no `e_fall` strobe.
- `rst` pulse of 1 cycle during HOLD → next cycle all outputs take reset values. The full sequence restarts.
- DIV=1 → E period 4 clk. Exactly one strobe per cycle in the rotation q_rise, e_rise, q_fall, e_fall.
- STRETCH_EN, DIV=2: `stretch`=1 for 5 cycles, starting at the last cycle of phase 3 → E high-time 4+5=9 clk. `e_fall` occurs 1 cycle after `stretch` drops.

Source files
------------

// File: rtl/mc6809_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : mc6809_clkgen
// Description : Clock-enable and reset sequencer for an MC6809 core.
//               Runs on the single PLL output clock. Synchronises and filters
//               the PLL lock flag. Once lock is stable it produces the
//               quadrature E/Q levels with one-cycle edge strobes, and holds
//               cpu_reset for RST_E_CYCLES E cycles.
//
// Parameters  : DIV          - clk cycles per quarter E period (1..255)
//               LOCK_FILTER  - stable-lock cycles required before E/Q start
//               RST_E_CYCLES - E falling edges with cpu_reset high after start
//
// Ports       : clk        in  PLL output clock (only clock)
//               rst        in  synchronous active-high reset
//               pll_locked in  PLL lock, asynchronous to clk
//               stretch    in  hold E high (only with MC6809_CLKGEN_STRETCH_EN)
//               e_out      out registered E level
//               q_out      out registered Q level
//               e_rise     out one-cycle strobe, first cycle of E high
//               e_fall     out one-cycle strobe, first cycle of E low
//               q_rise     out one-cycle strobe, first cycle of Q high
//               q_fall     out one-cycle strobe, first cycle of Q low
//               cpu_reset  out active-high CPU reset
//               running    out high in RUN state
//
// Options     : `define MC6809_CLKGEN_STRETCH_EN adds the stretch input,
//               which freezes the last cycle of the E-high/Q-low phase.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mc6809_clkgen #(
    parameter int DIV          = 10,
    parameter int LOCK_FILTER  = 1024,
    parameter int RST_E_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
`ifdef MC6809_CLKGEN_STRETCH_EN
    input  logic stretch,
`endif
    output logic e_out,
    output logic q_out,
    output logic e_rise,
    output logic e_fall,
    output logic q_rise,
    output logic q_fall,
    output logic cpu_reset,
    output logic running
);

    localparam int c_div_w  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_filt_w = $clog2(LOCK_FILTER + 1);
    localparam int c_hold_w = $clog2(RST_E_CYCLES + 1);

    localparam logic [c_div_w-1:0]  c_div_last    = c_div_w'(DIV - 1);
    localparam logic [c_filt_w-1:0] c_filt_target = c_filt_w'(LOCK_FILTER);
    localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(RST_E_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [c_filt_w-1:0]   r_filt_cnt;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_div_w-1:0]    r_div_cnt;
    logic [1:0]            r_phase;
    logic                  r_e;
    logic                  r_q;
    logic                  r_e_rise;
    logic                  r_e_fall;
    logic                  r_q_rise;
    logic                  r_q_fall;
    logic                  r_cpu_reset;
    logic                  r_running;

    logic                  w_lk_s;
    logic                  w_wrap;
    logic                  w_stall;
    logic [1:0]            w_phase_nx;
    logic [c_filt_w-1:0]   w_filt_inc;

    // Two-flop synchroniser. Left out of reset so that a lock already present
    // while rst is held is seen immediately after release.
    always_ff @(posedge clk) begin
        r_sync1 <= pll_locked;
        r_sync2 <= r_sync1;
    end

    assign w_lk_s = r_sync2;

    always_comb begin
        w_wrap     = (r_div_cnt == c_div_last);
        w_phase_nx = r_phase + 2'd1;
        w_stall    = 1'b0;
`ifdef MC6809_CLKGEN_STRETCH_EN
        // Only the final cycle of phase 3 is frozen; earlier cycles run on.
        w_stall    = stretch && (r_phase == 2'd3);
`endif
        // Saturating increment keeps the filter count from wrapping.
        w_filt_inc = (r_filt_cnt == c_filt_target) ? r_filt_cnt
                                                   : r_filt_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RESET;
            r_filt_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_div_cnt   <= '0;
            r_phase     <= 2'd0;
            r_e         <= 1'b0;
            r_q         <= 1'b0;
            r_e_rise    <= 1'b0;
            r_e_fall    <= 1'b0;
            r_q_rise    <= 1'b0;
            r_q_fall    <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
        end else begin
            r_e_rise <= 1'b0;
            r_e_fall <= 1'b0;
            r_q_rise <= 1'b0;
            r_q_fall <= 1'b0;

            case (r_state)
                ST_RESET: begin
                    r_state <= ST_WAIT_LOCK;
                end

                ST_WAIT_LOCK: begin
                    r_filt_cnt <= '0;
                    if (w_lk_s) begin
                        r_state <= ST_FILTER;
                    end
                end

                ST_FILTER: begin
                    if (!w_lk_s) begin
                        r_state    <= ST_WAIT_LOCK;
                        r_filt_cnt <= '0;
                    end else begin
                        r_filt_cnt <= w_filt_inc;
                        // Divider, phase and hold counter are already zero
                        // here, so HOLD starts at the beginning of phase 0.
                        if (w_filt_inc == c_filt_target) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD, ST_RUN: begin
                    if (!w_lk_s) begin
                        // Lock lost: drop E/Q silently and re-arm the filter.
                        r_state     <= ST_WAIT_LOCK;
                        r_div_cnt   <= '0;
                        r_phase     <= 2'd0;
                        r_hold_cnt  <= '0;
                        r_e         <= 1'b0;
                        r_q         <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_running   <= 1'b0;
                    end else if (!w_wrap) begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else if (!w_stall) begin
                        r_div_cnt <= '0;
                        r_phase   <= w_phase_nx;
                        // Levels and strobes are registered together, so a
                        // strobe marks the first cycle of the new level.
                        case (w_phase_nx)
                            2'd1: begin
                                r_q      <= 1'b1;
                                r_q_rise <= 1'b1;
                            end
                            2'd2: begin
                                r_e      <= 1'b1;
                                r_e_rise <= 1'b1;
                            end
                            2'd3: begin
                                r_q      <= 1'b0;
                                r_q_fall <= 1'b1;
                            end
                            default: begin
                                r_e      <= 1'b0;
                                r_e_fall <= 1'b1;
                                if (r_state == ST_HOLD) begin
                                    r_hold_cnt <= r_hold_cnt + 1'b1;
                                    // Release coincides with this e_fall.
                                    if (r_hold_cnt == c_hold_last) begin
                                        r_state     <= ST_RUN;
                                        r_cpu_reset <= 1'b0;
                                        r_running   <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign e_out     = r_e;
    assign q_out     = r_q;
    assign e_rise    = r_e_rise;
    assign e_fall    = r_e_fall;
    assign q_rise    = r_q_rise;
    assign q_fall    = r_q_fall;
    assign cpu_reset = r_cpu_reset;
    assign running   = r_running;

endmodule
`default_nettype wire

// File: tb/tb_mc6809_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc6809_clkgen
// Description : Self-checking bench for mc6809_clkgen. Three instances with
//               different DIV / LOCK_FILTER / RST_E_CYCLES share the inputs.
//               A model tracks elapsed E-clock position since HOLD entry and
//               derives levels, strobes and reset release arithmetically.
//               Output vector bit order:
//               {e_out, q_out, e_rise, e_fall, q_rise, q_fall, cpu_reset, running}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc6809_clkgen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pll_locked;
    logic stretch;
    logic chk_en      = 1'b0;
    logic rnd_stretch = 1'b0;

    wire [7:0] va;
    wire [7:0] vb;
    wire [7:0] vc;

    int n_vec = 0;
    int n_err = 0;

    mc6809_clkgen #(.DIV(2), .LOCK_FILTER(8), .RST_E_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
`ifdef MC6809_CLKGEN_STRETCH_EN
        .stretch(stretch),
`endif
        .e_out(va[7]), .q_out(va[6]), .e_rise(va[5]), .e_fall(va[4]),
        .q_rise(va[3]), .q_fall(va[2]), .cpu_reset(va[1]), .running(va[0])
    );

    mc6809_clkgen #(.DIV(1), .LOCK_FILTER(3), .RST_E_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
`ifdef MC6809_CLKGEN_STRETCH_EN
        .stretch(stretch),
`endif
        .e_out(vb[7]), .q_out(vb[6]), .e_rise(vb[5]), .e_fall(vb[4]),
        .q_rise(vb[3]), .q_fall(vb[2]), .cpu_reset(vb[1]), .running(vb[0])
    );

    mc6809_clkgen #(.DIV(3), .LOCK_FILTER(5), .RST_E_CYCLES(1)) u_c (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
`ifdef MC6809_CLKGEN_STRETCH_EN
        .stretch(stretch),
`endif
        .e_out(vc[7]), .q_out(vc[6]), .e_rise(vc[5]), .e_fall(vc[4]),
        .q_rise(vc[3]), .q_fall(vc[2]), .cpu_reset(vc[1]), .running(vc[0])
    );

    // ------------------------------------------------------------------
    // Reference model: mode 0 reset, 1 waiting, 2 filtering, 3 active.
    // In active mode t is the number of clk cycles the E clock has advanced
    // since HOLD entry; phase = (t/div) mod 4, completed E cycles = t/(4div).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0] mode;
        int         fcnt;
        int         t;
        logic       adv;
    } mst_t;

    function automatic mst_t mstep(input mst_t s, input int div, input int lf,
                                   input logic r, input logic lks, input logic st);
        mst_t n;
        n     = s;
        n.adv = 1'b0;
        if (r) begin
            n.mode = 2'd0;
            n.fcnt = 0;
            n.t    = 0;
        end else begin
            case (s.mode)
                2'd0: n.mode = 2'd1;
                2'd1: begin
                    n.fcnt = 0;
                    if (lks) n.mode = 2'd2;
                end
                2'd2: begin
                    if (!lks) begin
                        n.mode = 2'd1;
                        n.fcnt = 0;
                    end else if (s.fcnt + 1 >= lf) begin
                        n.mode = 2'd3;
                        n.t    = 0;
                    end else begin
                        n.fcnt = s.fcnt + 1;
                    end
                end
                default: begin
                    if (!lks) begin
                        n.mode = 2'd1;
                        n.t    = 0;
                    end else if (!(st && (s.t % (4 * div) == 4 * div - 1))) begin
                        n.t   = s.t + 1;
                        n.adv = 1'b1;
                    end
                end
            endcase
        end
        return n;
    endfunction

    function automatic logic [7:0] mout(input mst_t s, input int div, input int rste);
        logic [7:0] o;
        int         ph;
        o = 8'b0000_0010;
        if (s.mode == 2'd3) begin
            ph   = (s.t / div) % 4;
            o[7] = (ph >= 2);
            o[6] = (ph == 1) || (ph == 2);
            if (s.adv && (s.t % div == 0)) begin
                case (ph)
                    0:       o[4] = 1'b1;
                    1:       o[3] = 1'b1;
                    2:       o[5] = 1'b1;
                    default: o[2] = 1'b1;
                endcase
            end
            if (s.t >= rste * 4 * div) begin
                o[1] = 1'b0;
                o[0] = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    mst_t ma = '0;
    mst_t mb = '0;
    mst_t mc = '0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;

    always @(posedge clk) begin : p_model
        logic lks;
        logic st;
        lks = h2;
        h2  = h1;
        h1  = pll_locked;
        st  = 1'b0;
`ifdef MC6809_CLKGEN_STRETCH_EN
        st  = stretch;
`endif
        ma = mstep(ma, 2, 8, rst, lks, st);
        mb = mstep(mb, 1, 3, rst, lks, st);
        mc = mstep(mc, 3, 5, rst, lks, st);
        #1;
        if (chk_en) begin
            check("model_A", va, mout(ma, 2, 2));
            check("model_B", vb, mout(mb, 1, 3));
            check("model_C", vc, mout(mc, 3, 1));
        end
    end

    task automatic tick(input logic lk, input logic r);
        @(negedge clk);
        pll_locked = lk;
        rst        = r;
        stretch    = 1'b0;
`ifdef MC6809_CLKGEN_STRETCH_EN
        if (rnd_stretch) stretch = ($urandom_range(0, 3) == 0);
`endif
    endtask

    logic [7:0] vv [3];
    int         i_qr [3];
    int         i_er [3];
    int         i_ef [3];
    int         i_cr [3];
    int         e_qr [3] = '{11, 5, 9};
    int         e_er [3] = '{13, 6, 12};
    int         e_ef [3] = '{17, 8, 18};
    int         e_cr [3] = '{25, 16, 18};
    logic       found;
    int         saw_ef;
    int         r;

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        stretch    = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        check("reset_A", va, 8'b0000_0010);
        check("reset_B", vb, 8'b0000_0010);
        check("reset_C", vc, 8'b0000_0010);

        // Release with lock already present; record first event cycles.
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            i_qr[j] = -1; i_er[j] = -1; i_ef[j] = -1; i_cr[j] = -1;
        end
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            vv[0] = va; vv[1] = vb; vv[2] = vc;
            for (int j = 0; j < 3; j++) begin
                if (i_qr[j] < 0 && vv[j][3])  i_qr[j] = k;
                if (i_er[j] < 0 && vv[j][5])  i_er[j] = k;
                if (i_ef[j] < 0 && vv[j][4])  i_ef[j] = k;
                if (i_cr[j] < 0 && !vv[j][1]) i_cr[j] = k;
            end
        end
        for (int j = 0; j < 3; j++) begin
            check_int($sformatf("first_q_rise_%0d", j), i_qr[j], e_qr[j]);
            check_int($sformatf("first_e_rise_%0d", j), i_er[j], e_er[j]);
            check_int($sformatf("first_e_fall_%0d", j), i_ef[j], e_ef[j]);
            check_int($sformatf("cpu_reset_fall_%0d", j), i_cr[j], e_cr[j]);
        end

        // Lock loss in RUN right after E rises: no e_fall, outputs cleared.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (va[5]) found = 1'b1;
        end
        check_int("wait_e_rise_A", int'(found), 1);
        @(negedge clk);
        pll_locked = 1'b0;
        saw_ef = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (va[4]) saw_ef = 1;
        end
        check("lockloss_A", va, 8'b0000_0010);
        check_int("lockloss_no_e_fall", saw_ef, 0);

        // Relock, then a one-cycle rst pulse while A is in HOLD.
        @(negedge clk);
        pll_locked = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk);
            #1;
            if (va[3]) found = 1'b1;
        end
        check_int("wait_hold_A", int'(found), 1);
        check_int("hold_cpu_reset_A", int'(va[1]), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pulse_A", va, 8'b0000_0010);
        check("rst_pulse_B", vb, 8'b0000_0010);
        check("rst_pulse_C", vc, 8'b0000_0010);
        @(negedge clk);
        rst = 1'b0;

        // Randomised lock behaviour, reset pulses and (if present) stretch.
        rnd_stretch = 1'b1;
        for (int s = 0; s < 120; s++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                repeat ($urandom_range(1, 2)) tick(pll_locked, 1'b1);
            end else if (r < 12) begin
                repeat ($urandom_range(150, 260)) tick(1'b1, 1'b0);
            end else begin
                repeat ($urandom_range(1, 80)) tick(1'b1, 1'b0);
                repeat ($urandom_range(1, 5)) tick(1'b0, 1'b0);
            end
        end
        rnd_stretch = 1'b0;
        repeat (5) tick(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
